// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-side, D-side and physical-memory line ports seen by mem_port_arbiter.
// master: the arbiter itself; slave: the requesting caches plus the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges the I-cache read port and D-cache read/write port onto one memory line port.
// One transaction at a time, round-robin on ties, registered command outputs.
module mem_port_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned       OFFS_W     = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFFS_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t            state_q;
  grant_t            last_grant_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  logic d_req;
  logic take_i;
  logic take_d;

  // On a tie the side that did not win last time takes the port.
  always_comb begin
    d_req  = bus.d_read | bus.d_write;
    take_i = bus.i_read & (~d_req | (last_grant_q == GRANT_D));
    take_d = d_req & ~take_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_D;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_i) begin
            state_q        <= BUSY_I;
            last_grant_q   <= GRANT_I;
            pmem_address_q <= bus.i_address & ALIGN_MASK;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
          end else if (take_d) begin
            state_q        <= BUSY_D;
            last_grant_q   <= GRANT_D;
            pmem_address_q <= bus.d_address & ALIGN_MASK;
            // read+write together is resolved as a write
            pmem_read_q    <= ~bus.d_write;
            pmem_write_q   <= bus.d_write;
            if (bus.d_write) begin
              pmem_wdata_q <= bus.d_wdata;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.pmem_resp) begin
            state_q      <= DONE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Completion and read data are passed straight through in the response cycle.
  always_comb begin
    bus.pmem_read    = pmem_read_q;
    bus.pmem_write   = pmem_write_q;
    bus.pmem_address = pmem_address_q;
    bus.pmem_wdata   = pmem_wdata_q;
    bus.i_resp       = (state_q == BUSY_I) & bus.pmem_resp;
    bus.d_resp       = (state_q == BUSY_D) & bus.pmem_resp;
    bus.i_rdata      = bus.pmem_rdata;
    bus.d_rdata      = bus.pmem_rdata;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined datapath's split memory interface, behind the instruction and data caches.
- Merges the I-cache miss port (read-only) and the D-cache miss/writeback port (read/write) onto one physical-memory line port.
- Grants one requester at a time, with round-robin on ties so neither fetch nor load/store starves.
- Command outputs are registered; response and read data are passed through in the response cycle.

Parameters:
- LINE_W, 256, cache-line width in bits; must be a power of two and at least 8.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-side line read request; level, held until i_resp.
- i_address  in  ADDR_W  I-side byte address.
- i_rdata  out  LINE_W  I-side read line; valid only while i_resp=1.
- i_resp  out  1  I-side completion pulse, one cycle.
- d_read  in  1  D-side line read request; level.
- d_write  in  1  D-side line write request; level.
- d_address  in  ADDR_W  D-side byte address.
- d_wdata  in  LINE_W  D-side write line.
- d_rdata  out  LINE_W  D-side read line; valid only while d_resp=1.
- d_resp  out  1  D-side completion pulse, one cycle.
- pmem_read  out  1  memory read command; registered.
- pmem_write  out  1  memory write command; registered.
- pmem_address  out  ADDR_W  line-aligned address; low log2(LINE_W/8) bits are 0.
- pmem_wdata  out  LINE_W  registered write line.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_resp  in  1  memory completion, one cycle per command.

Behaviour:
States:
- IDLE, BUSY_I, BUSY_D, DONE; plus 1-bit last_grant register (I/D).

Reset (rst_n=0, asynchronous, any cycle including mid-transaction):
- state=IDLE, last_grant=D.
- pmem_read, pmem_write, i_resp, d_resp = 0.
- pmem_address and pmem_wdata = 0.
- Any in-flight memory command is abandoned; a pmem_resp arriving after reset is ignored.

IDLE:
- d_req = d_read|d_write.
- Only i_read=1: go to BUSY_I; latch i_address (aligned); pmem_read=1 next cycle.
- Only d_req=1: go to BUSY_D; latch d_address (aligned); latch d_wdata when writing. pmem_write=1 if d_write, else pmem_read=1.
- Both requesting: grant the side that is not last_grant.
- last_grant updates on every grant.

BUSY_x:
- Command outputs hold stable until pmem_resp.
- In the pmem_resp cycle, x_resp=1 combinationally. On a read, x_rdata=pmem_rdata in that same cycle.
- Next state is DONE. pmem_read/pmem_write deassert on the edge that leaves BUSY.

DONE:
- One cycle with all requests ignored, so the requester can drop its level request.
- Then IDLE.

Timing and handshake rules:
- Latency from request (seen in IDLE at cycle t) to memory command: command asserted at t+1.
- Earliest x_resp: t+2.
- Earliest next grant: resp cycle +2.
- pmem_resp outside BUSY is ignored.
- x_resp never asserts for a non-granted side.
- i_resp and d_resp are never high in the same cycle.
- d_read and d_write both high is illegal. The arbiter treats it as a write.
- Address and data changes on a held request after grant are ignored; latched values are used.
- i_rdata and d_rdata may mirror pmem_rdata at all times. Consumers qualify them with resp.

Test Plan:
1. Reset: rst_n=0 -> all outputs 0, state IDLE. Release, then i_read=1 with i_address=0x0000_0064 -> next cycle pmem_read=1, pmem_address=0x0000_0060.
2. I read: pmem_resp=1 three cycles later with pmem_rdata=0xA5 repeated -> i_resp=1 same cycle with i_rdata=pmem_rdata. Next cycle pmem_read=0, d_resp never asserted.
3. D write: d_write=1, d_address=0x8000_0040, d_wdata=0x1234 pattern -> pmem_write=1, pmem_address=0x8000_0040, pmem_wdata matches. pmem_resp -> d_resp one-cycle pulse.
4. Tie round-robin: from reset, i_read and d_read held high continuously -> grant order I, D, I, D. Each completes before the next command; a DONE gap appears between them.
5. Mid-transaction reset: in BUSY_D, assert rst_n=0 for 1 cycle, then drive pmem_resp=1 after release with no requests -> no d_resp, outputs remain 0.
6. Stray and illegal inputs: pmem_resp=1 while IDLE -> no resp. d_read=d_write=1 -> pmem_write=1, pmem_read=0.
